ysyx_22040750_clint_mh: RTL

//  Multi-hart core-local interruptor. Sits as an AXI-lite-style slave on the memory bus beside the SoC xbar.

---
 rtl/ysyx_22040750_clint_pkg.sv | 57 +++++
 rtl/ysyx_22040750_clint_prescaler.sv | 23 ++
 rtl/ysyx_22040750_clint_mh.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040750_clint_pkg.sv
// Shared CLINT register map, response codes and address decode helpers.
// Used by ysyx_22040750_clint_mh (CLINT_MTIME_WRITE_EN selects whether MTIME is writable).
package ysyx_22040750_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [2:0] hart;
    logic       hi;    // upper 32-bit lane of the 64-bit bus
  } dec_t;

  // Only naturally aligned registers that exist for this hart count decode.
  function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] base,
                                  input int nhart);
    logic [31:0] off, rel_m, rel_c;
    dec_t d;
    off   = addr - base;
    rel_m = off - 32'(MSIP_OFF);
    rel_c = off - 32'(MTIMECMP_OFF);
    d.sel  = SEL_NONE;
    d.hart = '0;
    d.hi   = off[2];
    if (rel_m[1:0] == 2'b00 && rel_m < 32'(4 * nhart)) begin
      d.sel  = SEL_MSIP;
      d.hart = rel_m[4:2];
    end else if (rel_c[2:0] == 3'b000 && rel_c < 32'(8 * nhart)) begin
      d.sel  = SEL_MTIMECMP;
      d.hart = rel_c[5:3];
    end else if (off == 32'(MTIME_OFF)) begin
      d.sel = SEL_MTIME;
    end
    return d;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old, input logic [63:0] data,
                                             input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22040750_clint_prescaler.sv
// Divides the clock into a one-cycle mtime tick every TICK_DIV clocks.
module ysyx_22040750_clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic I_clk,
  input  logic I_rst_n,
  output logic O_tick
);

  // Keep at least one counter bit so TICK_DIV=1 degenerates to a constant tick.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign O_tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)    cnt <= '0;
    else if (O_tick) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ysyx_22040750_clint_mh.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp/msip, AXI-lite style slave port.
// Define CLINT_MTIME_WRITE_EN to make MTIME writable; otherwise MTIME writes are dropped.
module ysyx_22040750_clint_mh
  import ysyx_22040750_clint_pkg::*;
#(
  parameter int          NHART     = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  output logic [NHART-1:0] O_mtip,
  output logic [NHART-1:0] O_msip,
  input  logic [31:0]      I_clint_araddr,
  input  logic             I_clint_arvalid,
  output logic             O_clint_arready,
  output logic [63:0]      O_clint_rdata,
  output logic [1:0]       O_clint_rresp,
  output logic             O_clint_rvalid,
  input  logic             I_clint_rready,
  input  logic [31:0]      I_clint_awaddr,
  input  logic             I_clint_awvalid,
  output logic             O_clint_awready,
  input  logic [63:0]      I_clint_wdata,
  input  logic [7:0]       I_clint_wstrb,
  input  logic             I_clint_wvalid,
  output logic             O_clint_wready,
  output logic [1:0]       O_clint_bresp,
  output logic             O_clint_bvalid,
  input  logic             I_clint_bready
);

  logic [63:0]             mtime;
  logic [NHART-1:0][63:0]  mtimecmp;
  logic [NHART-1:0]        msip;
  logic                    tick;

  logic        aw_held, w_held;
  logic [31:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;

  logic        ar_fire, aw_fire, w_fire, wr_go;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_lane_strb, wr_lane_bit, mtime_wr;
  dec_t        rd_dec, wr_dec;
  logic [63:0] rd_val, rd_word;
  logic        rd_bit;

  ysyx_22040750_clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .O_tick  (tick)
  );

  assign O_clint_arready = !O_clint_rvalid;
  assign O_clint_awready = !aw_held && !O_clint_bvalid;
  assign O_clint_wready  = !w_held && !O_clint_bvalid;

  // A write commits once both halves are present, whether latched earlier or handshaking now.
  always_comb begin
    ar_fire = I_clint_arvalid && O_clint_arready;
    aw_fire = I_clint_awvalid && O_clint_awready;
    w_fire  = I_clint_wvalid && O_clint_wready;
    wr_addr = aw_held ? aw_addr_q : I_clint_awaddr;
    wr_data = w_held ? w_data_q : I_clint_wdata;
    wr_strb = w_held ? w_strb_q : I_clint_wstrb;
    wr_go   = (aw_held || aw_fire) && (w_held || w_fire);
  end

  assign rd_dec = decode(I_clint_araddr, BASE_ADDR, NHART);
  assign wr_dec = decode(wr_addr, BASE_ADDR, NHART);

  assign wr_lane_strb = wr_dec.hi ? wr_strb[4] : wr_strb[0];
  assign wr_lane_bit  = wr_dec.hi ? wr_data[32] : wr_data[0];

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic [63:0] cmp_q;
    logic        msip_q;
    logic        cmp_we, msip_we;

    assign cmp_we  = wr_go && (wr_dec.sel == SEL_MTIMECMP) && (wr_dec.hart == 3'(h));
    assign msip_we = wr_go && (wr_dec.sel == SEL_MSIP) && (wr_dec.hart == 3'(h)) && wr_lane_strb;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        cmp_q  <= '1;
        msip_q <= 1'b0;
      end else begin
        if (cmp_we)  cmp_q  <= strb_merge(cmp_q, wr_data, wr_strb);
        if (msip_we) msip_q <= wr_lane_bit;
      end
    end

    assign mtimecmp[h] = cmp_q;
    assign msip[h]     = msip_q;
    assign O_mtip[h]   = (mtime >= cmp_q);
  end

  assign O_msip = msip;

`ifdef CLINT_MTIME_WRITE_EN
  assign mtime_wr = wr_go && (wr_dec.sel == SEL_MTIME);
`else
  assign mtime_wr = 1'b0;
`endif

  // A software write to mtime swallows a coincident tick.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)      mtime <= '0;
    else if (mtime_wr) mtime <= strb_merge(mtime, wr_data, wr_strb);
    else if (tick)     mtime <= mtime + 64'd1;
  end

  always_comb begin
    rd_word = '0;
    rd_bit  = 1'b0;
    rd_val  = '0;
    for (int h = 0; h < NHART; h++) begin
      if (rd_dec.hart == 3'(h)) begin
        rd_word = mtimecmp[h];
        rd_bit  = msip[h];
      end
    end
    case (rd_dec.sel)
      SEL_MSIP:     rd_val = rd_dec.hi ? {31'b0, rd_bit, 32'b0} : {63'b0, rd_bit};
      SEL_MTIMECMP: rd_val = rd_word;
      SEL_MTIME:    rd_val = mtime;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_clint_rvalid <= 1'b0;
      O_clint_rdata  <= '0;
      O_clint_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      O_clint_rvalid <= 1'b1;
      O_clint_rdata  <= rd_val;
      O_clint_rresp  <= (rd_dec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
    end else if (I_clint_rready) begin
      O_clint_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      O_clint_bvalid <= 1'b0;
      O_clint_bresp  <= RESP_OKAY;
    end else if (wr_go) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      O_clint_bvalid <= 1'b1;
      O_clint_bresp  <= (wr_dec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= I_clint_awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= I_clint_wdata;
        w_strb_q <= I_clint_wstrb;
      end
      if (O_clint_bvalid && I_clint_bready) O_clint_bvalid <= 1'b0;
    end
  end

endmodule
